// File: rtl/axi_stream_strip_header_pkg.sv
// Shared types and byte-lane helpers for the AXI-Stream header strip/insert blocks.
// Lane numbering: lane N-1 (MSB) carries the first byte; keep is contiguous from the MSB.
package axi_stream_strip_header_pkg;

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_HEAD  = 2'd1,
        S_BODY  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    localparam int MAX_BYTES = 64;

    // Keep mask with the top cnt lanes of an nbytes-wide beat set.
    function automatic logic [MAX_BYTES-1:0] lane_mask(input int nbytes, input int cnt);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < nbytes) && (i >= nbytes - cnt);
        end
        return m;
    endfunction

    function automatic int keep_count(input logic [MAX_BYTES-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            n += int'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_byte_shifter.sv
// Realigns one beat: residual (top R lanes) joined with the first S bytes of the new beat.
// Combinational, zero latency; no flow control of its own.
// Also returns the new beat's remaining bytes moved to the top lanes as the next residual.
module axis_byte_shifter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int SW           = 3
) (
    input  logic [DATA_WD-1:0]      res_dat,
    input  logic [DATA_BYTE_WD-1:0] res_keep,
    input  logic [DATA_WD-1:0]      in_dat,
    input  logic [DATA_BYTE_WD-1:0] in_keep,
    input  logic [SW-1:0]           s,
    output logic [DATA_WD-1:0]      out_dat,
    output logic [DATA_BYTE_WD-1:0] out_keep,
    output logic [DATA_WD-1:0]      nxt_dat,
    output logic [DATA_BYTE_WD-1:0] nxt_keep
);
    localparam logic [SW-1:0] NB = SW'(DATA_BYTE_WD);

    logic [SW-1:0] r;

    // Residual lane count is fixed at N-S for every non-last beat.
    assign r        = NB - s;
    assign out_dat  = res_dat | (in_dat >> {r, 3'b000});
    assign out_keep = res_keep | (in_keep >> r);
    assign nxt_dat  = in_dat << {s, 3'b000};
    assign nxt_keep = in_keep << s;

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips the first S=byte_strip_cnt+1 bytes of each packet; AXI_STREAM_STRIP_HEADER_OUT_EN exposes them.
// Latency: one cycle (registered output); a packet with V>S bytes in its last beat adds one flush beat.
// Backpressure: ready_in follows the output register (full throughput); ready_strip only between packets.
module axi_stream_strip_header
    import axi_stream_strip_header_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic                    last_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic                    last_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
`endif
    input  logic                    valid_strip,
    output logic                    ready_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt
);
    localparam int SW = BYTE_CNT_WD + 1;

    state_e                  state_q, state_d;
    logic [SW-1:0]           s_q, s_d;
    logic [DATA_WD-1:0]      res_dat_q, res_dat_d;
    logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;
    logic                    out_vld_q, out_vld_d;
    logic                    out_last_q, out_last_d;
    logic [DATA_WD-1:0]      out_dat_q, out_dat_d;
    logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;

    logic [DATA_WD-1:0]      din_m, sh_dat, nxt_dat;
    logic [DATA_BYTE_WD-1:0] sh_keep, nxt_keep;
    logic                    out_free, in_acc;

    function automatic logic [DATA_WD-1:0] keep_to_bytes(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[i*8 +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    // Lanes outside keep are zeroed on entry so every downstream shift stays clean.
    assign din_m       = data_in & keep_to_bytes(keep_in);
    assign out_free    = !out_vld_q || ready_out;
    assign ready_in    = ((state_q == S_HEAD) || (state_q == S_BODY)) && out_free;
    assign in_acc      = valid_in && ready_in;
    assign ready_strip = (state_q == S_CMD);

    assign valid_out = out_vld_q;
    assign last_out  = out_last_q;
    assign data_out  = out_dat_q;
    assign keep_out  = out_keep_q;

    axis_byte_shifter #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .SW           (SW)
    ) u_shifter (
        .res_dat  (res_dat_q),
        .res_keep (res_keep_q),
        .in_dat   (din_m),
        .in_keep  (keep_in),
        .s        (s_q),
        .out_dat  (sh_dat),
        .out_keep (sh_keep),
        .nxt_dat  (nxt_dat),
        .nxt_keep (nxt_keep)
    );

`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
    logic                    hdr_vld_q, hdr_vld_d;
    logic [DATA_WD-1:0]      hdr_dat_q, hdr_dat_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;
    logic [MAX_BYTES-1:0]    s_mask_full;
    logic [DATA_BYTE_WD-1:0] s_keep;

    assign s_mask_full  = lane_mask(DATA_BYTE_WD, int'(s_q));
    assign s_keep       = s_mask_full[DATA_BYTE_WD-1:0];
    assign valid_header = hdr_vld_q;
    assign data_header  = hdr_dat_q;
    assign keep_header  = hdr_keep_q;
`endif

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        res_dat_d  = res_dat_q;
        res_keep_d = res_keep_q;
        out_vld_d  = out_vld_q && !ready_out;
        out_last_d = out_last_q;
        out_dat_d  = out_dat_q;
        out_keep_d = out_keep_q;
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
        hdr_vld_d  = 1'b0;
        hdr_dat_d  = hdr_dat_q;
        hdr_keep_d = hdr_keep_q;
`endif
        unique case (state_q)
            S_CMD: begin
                if (valid_strip) begin
                    s_d     = SW'(byte_strip_cnt) + SW'(1);
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (in_acc) begin
                    res_dat_d  = nxt_dat;
                    res_keep_d = nxt_keep;
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
                    hdr_vld_d  = 1'b1;
                    hdr_dat_d  = din_m & keep_to_bytes(s_keep);
                    hdr_keep_d = s_keep;
`endif
                    if (!last_in) begin
                        state_d = S_BODY;
                    end else begin
                        state_d = S_CMD;
                        // Single-beat packet longer than S: its tail is the whole output.
                        if (|nxt_keep) begin
                            out_vld_d  = 1'b1;
                            out_dat_d  = nxt_dat;
                            out_keep_d = nxt_keep;
                            out_last_d = 1'b1;
                        end
                    end
                end
            end
            S_BODY: begin
                if (in_acc) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = sh_dat;
                    out_keep_d = sh_keep;
                    out_last_d = last_in && !(|nxt_keep);
                    res_dat_d  = nxt_dat;
                    res_keep_d = nxt_keep;
                    if (last_in) begin
                        state_d = (|nxt_keep) ? S_FLUSH : S_CMD;
                    end
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = res_dat_q;
                    out_keep_d = res_keep_q;
                    out_last_d = 1'b1;
                    state_d    = S_CMD;
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CMD;
            s_q        <= '0;
            res_dat_q  <= '0;
            res_keep_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_dat_q  <= '0;
            out_keep_q <= '0;
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
            hdr_vld_q  <= 1'b0;
            hdr_dat_q  <= '0;
            hdr_keep_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            res_dat_q  <= res_dat_d;
            res_keep_q <= res_keep_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_dat_q  <= out_dat_d;
            out_keep_q <= out_keep_d;
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
            hdr_vld_q  <= hdr_vld_d;
            hdr_dat_q  <= hdr_dat_d;
            hdr_keep_q <= hdr_keep_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: directed cases, stall/reset cases, then random packets
// checked against a byte-list reference model (drop first S bytes, repack MSB-first).
module tb_axi_stream_strip_header;
    localparam int DW   = 32;
    localparam int NB   = 4;
    localparam int NPKT = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in, ready_in, last_in;
    logic [DW-1:0] data_in, data_out;
    logic [NB-1:0] keep_in, keep_out;
    logic          valid_out, ready_out, last_out;
    logic          valid_strip, ready_strip;
    logic [1:0]    byte_strip_cnt;
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
    logic          valid_header;
    logic [DW-1:0] data_header;
    logic [NB-1:0] keep_header;
`endif

    always #5 clk = ~clk;

    axi_stream_strip_header #(.DATA_WD(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .last_in        (last_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .last_out       (last_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
        .valid_header   (valid_header),
        .data_header    (data_header),
        .keep_header    (keep_header),
`endif
        .valid_strip    (valid_strip),
        .ready_strip    (ready_strip),
        .byte_strip_cnt (byte_strip_cnt)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [36:0] exp_q[$];
    logic [35:0] hdr_q[$];
    logic [7:0]  pkt_q[$];
    bit          rdy_rand = 1'b0;
    bit          prev_stall = 1'b0;
    logic [36:0] prev_beat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bail(input string tag, input logic got);
        check(tag, 64'(got), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "handshake timeout");
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: output bytes are the packet minus its first s bytes, N per beat, MSB first.
    task automatic model_push(input int s, input bit want_out);
        int          len;
        logic [31:0] d;
        logic [3:0]  k;
        len = pkt_q.size();
        if (want_out) begin
            for (int b = s; b < len; b += NB) begin
                d = '0;
                k = '0;
                for (int j = 0; j < NB; j++) begin
                    if (b + j < len) begin
                        d[8*(NB-1-j) +: 8] = pkt_q[b+j];
                        k[NB-1-j]          = 1'b1;
                    end
                end
                exp_q.push_back({(b + NB >= len), k, d});
            end
        end
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
        d = '0;
        k = '0;
        for (int j = 0; j < s; j++) begin
            k[NB-1-j] = 1'b1;
            if (j < len) d[8*(NB-1-j) +: 8] = pkt_q[j];
        end
        hdr_q.push_back({k, d});
`endif
    endtask

    task automatic gen_pkt(input int len);
        pkt_q.delete();
        for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
    endtask

    // Lanes outside keep carry random junk; the DUT must not pass it through.
    task automatic get_beat(input int b, output logic [31:0] d, output logic [3:0] k, output logic l);
        int len;
        len = pkt_q.size();
        d   = $urandom;
        k   = '0;
        for (int j = 0; j < NB; j++) begin
            if (b*NB + j < len) begin
                d[8*(NB-1-j) +: 8] = pkt_q[b*NB+j];
                k[NB-1-j]          = 1'b1;
            end
        end
        l = ((b + 1) * NB >= len);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic acc;
        acc      = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = ready_in;
            tick();
        end
        if (!acc) bail("in_timeout", ready_in);
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic send_cmd(input int cnt);
        logic acc;
        acc            = 1'b0;
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'(cnt);
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = ready_strip;
            tick();
        end
        if (!acc) bail("cmd_timeout", ready_strip);
        valid_strip = 1'b0;
    endtask

    task automatic drive_pkt(input bit fork_next, input int next_cnt);
        int          nbeats;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        nbeats = (pkt_q.size() + NB - 1) / NB;
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) tick();
            get_beat(b, d, k, l);
            if (b == nbeats - 1 && fork_next) begin
                fork
                    send_beat(d, k, l);
                    send_cmd(next_cnt);
                join
            end else begin
                send_beat(d, k, l);
            end
        end
    endtask

    initial begin
        forever begin
            tick();
            if (rdy_rand) ready_out = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", 64'(valid_out), 64'd1);
                check("hold_beat", 64'({last_out, keep_out, data_out}), 64'(prev_beat));
            end
            if (valid_out && !ready_out) check("stall_rdy_in", 64'(ready_in), 64'd0);
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) check("unexp_beat", 64'(valid_out), 64'd0);
                else check("beat", 64'({last_out, keep_out, data_out}), 64'(exp_q.pop_front()));
            end
            prev_stall = valid_out && !ready_out;
            prev_beat  = {last_out, keep_out, data_out};
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
            if (valid_header) begin
                if (hdr_q.size() == 0) check("unexp_hdr", 64'(valid_header), 64'd0);
                else check("hdr", 64'({keep_header, data_header}), 64'(hdr_q.pop_front()));
            end
`endif
        end
    end

    initial begin
        logic [31:0] bd [3];
        logic [3:0]  bk [3];
        logic        bl [3];
        int          cnt, nxt;

        rst_n = 1'b0; valid_in = 1'b0; last_in = 1'b0; data_in = '0; keep_in = '0;
        valid_strip = 1'b0; byte_strip_cnt = '0; ready_out = 1'b0;
        repeat (2) tick();
        check("rst_vld", 64'(valid_out), 64'd0);
        check("rst_last", 64'(last_out), 64'd0);
        check("rst_dat", 64'(data_out), 64'd0);
        check("rst_keep", 64'(keep_out), 64'd0);
        check("rst_rdy_in", 64'(ready_in), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_rdy_strip", 64'(ready_strip), 64'd1);
        ready_out = 1'b1;

        // S=1, two full beats.
        send_cmd(0);
        exp_q.push_back({1'b0, 4'hF, 32'h22334455});
        exp_q.push_back({1'b1, 4'hE, 32'h66778800});
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
        hdr_q.push_back({4'h8, 32'h11000000});
`endif
        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hF, 1'b1);

        // S=4, pass-through after the first beat.
        send_cmd(3);
        exp_q.push_back({1'b0, 4'hF, 32'hB0B1B2B3});
        exp_q.push_back({1'b1, 4'hC, 32'hC0C10000});
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
        hdr_q.push_back({4'hF, 32'hA0A1A2A3});
`endif
        send_beat(32'hA0A1A2A3, 4'hF, 1'b0);
        check("s4_head_quiet", 64'(valid_out), 64'd0);
        send_beat(32'hB0B1B2B3, 4'hF, 1'b0);
        check("s4_lat_vld", 64'(valid_out), 64'd1);
        check("s4_lat_dat", 64'(data_out), 64'hB0B1B2B3);
        send_beat(32'hC0C1C2C3, 4'hC, 1'b1);

        // S=3, single short beat: header only.
        send_cmd(2);
`ifdef AXI_STREAM_STRIP_HEADER_OUT_EN
        hdr_q.push_back({4'hE, 32'hAABBCC00});
`endif
        send_beat(32'hAABBCCDD, 4'hE, 1'b1);
        check("s3_back_cmd", 64'(ready_strip), 64'd1);
        check("s3_quiet", 64'(valid_out), 64'd0);

        // S=2, 3 beats with a 3-cycle downstream stall mid-packet.
        send_cmd(1);
        gen_pkt(12);
        model_push(2, 1'b1);
        for (int b = 0; b < 3; b++) get_beat(b, bd[b], bk[b], bl[b]);
        send_beat(bd[0], bk[0], bl[0]);
        ready_out = 1'b0;
        send_beat(bd[1], bk[1], bl[1]);
        fork
            send_beat(bd[2], bk[2], bl[2]);
            begin
                repeat (3) tick();
                ready_out = 1'b1;
            end
        join

        // Reset in S_BODY with a stalled output beat pending.
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
        ready_out = 1'b0;
        send_cmd(1);
        gen_pkt(12);
        model_push(2, 1'b0);
        get_beat(0, bd[0], bk[0], bl[0]);
        send_beat(bd[0], bk[0], bl[0]);
        get_beat(1, bd[1], bk[1], bl[1]);
        send_beat(bd[1], bk[1], bl[1]);
        rst_n = 1'b0;
        #1;
        check("mrst_vld", 64'(valid_out), 64'd0);
        check("mrst_last", 64'(last_out), 64'd0);
        check("mrst_dat", 64'(data_out), 64'd0);
        check("mrst_keep", 64'(keep_out), 64'd0);
        check("mrst_rdy_in", 64'(ready_in), 64'd0);
        tick();
        rst_n = 1'b1;
        ready_out = 1'b1;
        tick();
        send_cmd(2);
        gen_pkt(10);
        model_push(3, 1'b1);
        drive_pkt(1'b0, 0);

        // Random packets, next command raised alongside each last beat.
        rdy_rand = 1'b1;
        cnt = $urandom_range(0, 3);
        send_cmd(cnt);
        for (int p = 0; p < NPKT && failures < 50; p++) begin
            nxt = $urandom_range(0, 3);
            gen_pkt($urandom_range(1, 4 * NB));
            model_push(cnt + 1, 1'b1);
            drive_pkt(p != NPKT - 1, nxt);
            cnt = nxt;
        end

        rdy_rand = 1'b0;
        ready_out = 1'b1;
        for (int t = 0; t < 1000 && (exp_q.size() != 0 || hdr_q.size() != 0); t++) tick();
        check("drain_out", 64'(exp_q.size()), 64'd0);
        check("drain_hdr", 64'(hdr_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
